// File: rtl/sort_result_serializer.sv
// Serializes one sorted NUM_LANES-wide vector into lane-per-beat output, lane 0 first.
// Latency: first beat valid one cycle after capture; back-to-back vectors stream without bubbles.
// Backpressure: out_ready stalls emission; one pending slot absorbs a new vector, further ones are dropped and flagged.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid, in_data   one-cycle strobe carrying a complete sorted vector (lane 0 at LSBs)
//   in_ready            pending slot empty; a vector presented now will be kept
//   out_valid/out_ready valid/ready handshake for the lane stream
//   out_data, out_index current lane value and its lane number
//   out_last            high on lane NUM_LANES-1
//   overflow            sticky: a vector was dropped since reset
//   busy                an active or pending vector is held
module sort_result_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_LANES  = 4,
    parameter int IDX_WIDTH  = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] in_data,
    output logic                            in_ready,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [IDX_WIDTH-1:0]            out_index,
    output logic                            out_last,
    output logic                            overflow,
    output logic                            busy
);

    localparam int VEC_W = NUM_LANES * DATA_WIDTH;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_LANES - 1);

    logic [0:0]           state_q, state_d;
    logic [VEC_W-1:0]     act_q, act_d;
    logic [VEC_W-1:0]     pend_q, pend_d;
    logic                 pend_full_q, pend_full_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic                 ovf_q, ovf_d;

    logic                 beat_hs;
    logic                 last_hs;
    logic [DATA_WIDTH-1:0] cur_lane;

    // The active slot is full exactly when we are sending.
    assign out_valid = (state_q == S_SEND);
    assign beat_hs   = out_valid && out_ready;
    assign last_hs   = beat_hs && (idx_q == LAST_IDX);

    always_comb begin
        cur_lane = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (idx_q == IDX_WIDTH'(i)) begin
                cur_lane = act_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Data fields are zeroed when idle so stale lanes never leak onto the bus.
    assign out_data  = out_valid ? cur_lane : '0;
    assign out_index = out_valid ? idx_q : '0;
    assign out_last  = out_valid && (idx_q == LAST_IDX);
    assign in_ready  = !pend_full_q;
    assign overflow  = ovf_q;
    assign busy      = out_valid || pend_full_q;

    always_comb begin
        state_d     = state_q;
        act_d       = act_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        idx_d       = idx_q;
        ovf_d       = ovf_q;

        case (state_q)
            S_IDLE: begin
                // Pending is always empty while idle, so go straight to active.
                if (in_valid) begin
                    act_d   = in_data;
                    idx_d   = '0;
                    state_d = S_SEND;
                end
            end
            default: begin
                if (last_hs) begin
                    if (pend_full_q) begin
                        act_d       = pend_q;
                        idx_d       = '0;
                        pend_full_d = 1'b0;
                        // in_ready was low this cycle, so a coincident vector is lost.
                        if (in_valid) begin
                            ovf_d = 1'b1;
                        end
                    end else if (in_valid) begin
                        act_d = in_data;
                        idx_d = '0;
                    end else begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                    end
                end else begin
                    if (beat_hs) begin
                        idx_d = idx_q + 1'b1;
                    end
                    if (in_valid) begin
                        if (!pend_full_q) begin
                            pend_d      = in_data;
                            pend_full_d = 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            act_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            idx_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            idx_q       <= idx_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_sort_result_serializer.sv
// Self-checking bench for sort_result_serializer with a beat scoreboard.
// Inputs driven 1 time unit after the rising edge; outputs sampled on the falling edge.
// Expected beats are queued when a vector is presented and popped on each handshake.
module tb_sort_result_serializer;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] i;
        logic       l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic [1:0]  out_index;
    logic        out_last;
    logic        overflow;
    logic        busy;

    int total = 0;
    int bad   = 0;

    beat_t exp_q[$];

    logic       stall_q = 1'b0;
    logic [7:0] stall_d = '0;
    logic [1:0] stall_i = '0;

    sort_result_serializer #(
        .DATA_WIDTH(8),
        .NUM_LANES (4),
        .IDX_WIDTH (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_index(out_index),
        .out_last (out_last),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_vec(input logic [31:0] v);
        beat_t b;
        for (int k = 0; k < 4; k++) begin
            b.d = v[k*8 +: 8];
            b.i = 2'(k);
            b.l = (k == 3);
            exp_q.push_back(b);
        end
    endtask

    // Present a vector for one cycle; queue its beats only when it should be kept.
    task automatic send(input logic [31:0] v, input bit keep);
        in_valid = 1'b1;
        in_data  = v;
        if (keep) push_vec(v);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_done", exp_q.size(), 0);
        tick();
        chk("idle_vld", out_valid, 0);
        chk("idle_busy", busy, 0);
    endtask

    // Scoreboard and stall-stability monitor.
    always @(negedge clk) begin
        beat_t e;
        if (out_valid && out_ready && !rst) begin
            if (exp_q.size() == 0) begin
                chk("extra_beat", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", out_data, e.d);
                chk("beat_idx", out_index, e.i);
                chk("beat_last", out_last, e.l);
            end
        end
        if (stall_q && !rst) begin
            chk("stall_vld", out_valid, 1);
            chk("stall_data", out_data, stall_d);
            chk("stall_idx", out_index, stall_i);
        end
        stall_q = out_valid && !out_ready && !rst;
        stall_d = out_data;
        stall_i = out_index;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic pat [7];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset, with a stray in_valid that must be ignored.
        rst = 1'b1;
        tick();
        in_valid = 1'b1;
        in_data  = 32'h11223344;
        tick();
        in_valid = 1'b0;
        rst = 1'b0;
        chk("rst_vld", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_idx", out_index, 0);
        chk("rst_last", out_last, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_inrdy", in_ready, 1);

        // Single vector, one-cycle latency.
        out_ready = 1'b1;
        send(32'h40302010, 1'b1);
        chk("lat_vld", out_valid, 1);
        chk("lat_data", out_data, 8'h10);
        drain();

        // Backpressure pattern.
        out_ready = 1'b0;
        send(32'h40302010, 1'b1);
        for (int k = 0; k < 7; k++) begin
            out_ready = pat[k];
            tick();
        end
        out_ready = 1'b1;
        drain();

        // Back-to-back vectors: eight beats with no bubble.
        send(32'h04030201, 1'b1);
        chk("b2b_v0", out_valid, 1);
        tick();
        chk("b2b_v1", out_valid, 1);
        send(32'h08070605, 1'b1);
        chk("b2b_v2", out_valid, 1);
        chk("b2b_rdy2", in_ready, 0);
        tick();
        chk("b2b_v3", out_valid, 1);
        chk("b2b_rdy3", in_ready, 0);
        tick();
        chk("b2b_v4", out_valid, 1);
        chk("b2b_rdy4", in_ready, 1);
        chk("b2b_data4", out_data, 8'h05);
        for (int k = 5; k < 8; k++) begin
            tick();
            chk("b2b_vn", out_valid, 1);
        end
        tick();
        chk("b2b_end", out_valid, 0);
        drain();

        // Overflow: A active, B pending, C dropped.
        out_ready = 1'b0;
        send(32'hA3A2A1A0, 1'b1);
        send(32'hB3B2B1B0, 1'b1);
        chk("ovf_before", overflow, 0);
        chk("ovf_inrdy", in_ready, 0);
        send(32'hC3C2C1C0, 1'b0);
        chk("ovf_set", overflow, 1);
        chk("ovf_busy", busy, 1);
        tick();
        tick();
        chk("ovf_hold", overflow, 1);
        out_ready = 1'b1;
        drain();
        chk("ovf_sticky", overflow, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ovf_clr", overflow, 0);

        // Same-cycle refill on the last beat.
        out_ready = 1'b1;
        send(32'h44332211, 1'b1);
        tick();
        tick();
        tick();
        chk("refill_last", out_last, 1);
        send(32'hDDCCBBAA, 1'b1);
        chk("refill_vld", out_valid, 1);
        chk("refill_data", out_data, 8'hAA);
        chk("refill_idx", out_index, 0);
        chk("refill_ovf", overflow, 0);
        drain();

        // Reset mid-stream after lane 1 is accepted.
        send(32'h06070809, 1'b1);
        tick();
        tick();
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        chk("mid_vld", out_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_ovf", overflow, 0);
        exp_q.delete();
        rst = 1'b0;
        tick();
        chk("mid_idle", out_valid, 0);
        out_ready = 1'b1;
        send(32'h5A4B3C2D, 1'b1);
        chk("mid_fresh_idx", out_index, 0);
        chk("mid_fresh_data", out_data, 8'h2D);
        drain();

        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sort_result_serializer.md
Name: sort_result_serializer

Overview:
- Drain-side companion to the compare-swap sorting network.
- Captures one sorted NUM_LANES-wide result vector when the network's output valid pulses, then emits the lanes one per beat, lane 0 first, on a valid/ready stream.
- Holds one in-flight vector plus one pending vector, because the sorting network cannot be stalled; a vector arriving with no free slot is dropped and flagged.

Parameters:
- DATA_WIDTH, 8, width of each lane/element.
- NUM_LANES, 4, elements per sorted vector; must be >= 2.
- IDX_WIDTH, 2, width of the lane index; must satisfy 2**IDX_WIDTH >= NUM_LANES.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  one-cycle strobe: in_data holds a complete sorted vector.
- in_data  input  NUM_LANES*DATA_WIDTH  packed vector; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH], lane 0 at the LSBs.
- in_ready  output  1  high when the pending slot is empty (a vector presented now will be accepted).
- out_valid  output  1  out_data/out_index/out_last are valid.
- out_ready  input  1  downstream accepts the current beat.
- out_data  output  DATA_WIDTH  current lane value.
- out_index  output  IDX_WIDTH  lane number of the current beat, 0..NUM_LANES-1.
- out_last  output  1  high with out_valid on lane NUM_LANES-1.
- overflow  output  1  sticky: a vector was dropped since reset.
- busy  output  1  active or pending vector held.

Behaviour:
- Reset values (rst high at an edge): out_valid=0, out_data=0, out_index=0, out_last=0, overflow=0, busy=0, active and pending slots empty, state IDLE.
- Reset mid-stream discards both slots with no further beats. in_valid during rst is ignored and does not set overflow.
- Storage: active register (vector being emitted) and pending register (next vector). in_ready = !pending_full; it is driven purely from registers.
- State IDLE (active empty):
  - in_valid -> capture into active, idx=0, go SEND.
  - out_valid rises the cycle after capture, with lane 0: latency 1 cycle.
- State SEND:
  - out_data = active lane idx, out_index = idx, out_last = (idx == NUM_LANES-1).
  - Outputs stay stable while out_valid && !out_ready.
- Beat handshake (out_valid && out_ready) on idx < NUM_LANES-1: idx increments.
- Handshake on the last lane:
  - If pending full: pending moves to active, idx=0, pending cleared. out_valid stays high; no bubble.
  - Else if in_valid the same cycle: in_data loads directly into active, idx=0. out_valid stays high.
  - Else: go IDLE; out_valid=0 next cycle.
- in_valid in SEND when not on a completing last beat:
  - Pending empty: store in pending.
  - Pending full: vector dropped, overflow set to 1 next cycle, held until rst. Active and pending are unaffected.
- Last-beat completion with pending full, plus in_valid the same cycle: in_ready was low, so the new vector is dropped and overflow is set. Pending is not refilled that cycle.
- Throughput: continuous out_ready=1 yields NUM_LANES beats per vector with back-to-back vectors and no idle cycles.
- Values pass through unmodified; no sign handling; emission order is exactly lane order.
- busy = active_full || pending_full.

Test Plan:
- Single vector: rst 2 cycles, then in_valid one cycle with lanes {0x10,0x20,0x30,0x40}, out_ready=1 -> out_valid from next cycle for 4 cycles. Expected out_data 0x10,0x20,0x30,0x40, out_index 0..3, out_last only on 0x40; then out_valid=0, busy=0.
- Backpressure: same vector, out_ready toggled 1,0,0,1,1,0,1 -> each lane appears once in order. out_data/out_index stay stable during ready-low cycles; no duplicated or lost beats.
- Back-to-back vectors: vector A {1,2,3,4}, then vector B {5,6,7,8} two cycles later, out_ready=1 -> eight consecutive beats 1..8 with no bubble. out_last on 4 and 8; in_ready low from B's capture until A's last beat.
- Overflow: with out_ready=0, present A, B, C one cycle apart -> A held in active, B in pending, C dropped. overflow=1 from the cycle after C and stays high. Releasing out_ready emits A then B only.
- Same-cycle refill: pending empty, in_valid {0xAA,0xBB,0xCC,0xDD} on the cycle lane 3 of the prior vector handshakes -> next cycle out_valid=1 with out_data=0xAA, out_index=0; overflow stays 0.
- Reset mid-stream: assert rst after lane 1 of {9,8,7,6} is accepted -> next cycle out_valid=0, busy=0, overflow=0. After rst a fresh vector emits from lane 0.
